// File: rtl/key_port.sv
// Three-key pushbutton port: synchronize, debounce, capture presses, and expose
// level/edge/mask registers with a masked interrupt to a processor bus.
module key_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [2:0]  KEY_n,
  input  logic        cs,
  input  logic [1:0]  ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] DIN,
  output logic        IRQ
);

  localparam int unsigned NKEYS = 3;
  localparam int unsigned CW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0] sync1_q, sync2_q;
  logic [NKEYS-1:0] lvl_q, lvl_d;
  logic [NKEYS-1:0] edge_q, edge_d;
  logic [NKEYS-1:0] mask_q, mask_d;
  logic [CW-1:0]    cnt_q [NKEYS];
  logic [CW-1:0]    cnt_d [NKEYS];
  logic [15:0]      din_q, din_d;
  logic             irq_q, irq_d;
  logic [NKEYS-1:0] s;
  logic [NKEYS-1:0] press;
  logic             wr;
  logic             unused_dout;

  assign s           = ~sync2_q;
  assign wr          = cs && W;
  assign unused_dout = ^DOUT[15:NKEYS];

  // Debounce, edge capture, register writes and read mux
  always_comb begin
    lvl_d  = lvl_q;
    edge_d = edge_q;
    mask_d = mask_q;
    cnt_d  = cnt_q;
    din_d  = 16'h0000;
    irq_d  = |(edge_q & mask_q);

    for (int i = 0; i < int'(NKEYS); i++) begin
      if (s[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        lvl_d[i] = ~lvl_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end

    press = lvl_d & ~lvl_q;

    // Clear first so a same-cycle press overrides the write-1-to-clear
    if (wr && (ADDR == 2'd1)) edge_d = edge_q & ~DOUT[NKEYS-1:0];
    edge_d = edge_d | press;

    if (wr && (ADDR == 2'd2)) mask_d = DOUT[NKEYS-1:0];

    case (ADDR)
      2'd0:    din_d = {13'h0000, lvl_q};
      2'd1:    din_d = {13'h0000, edge_q};
      2'd2:    din_d = {13'h0000, mask_q};
      default: din_d = 16'h0000;
    endcase
  end

  // Synchronizers reset to the released (high) raw level
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      lvl_q   <= '0;
      edge_q  <= '0;
      mask_q  <= '0;
      din_q   <= '0;
      irq_q   <= 1'b0;
      for (int i = 0; i < int'(NKEYS); i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= KEY_n;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      edge_q  <= edge_d;
      mask_q  <= mask_d;
      din_q   <= din_d;
      irq_q   <= irq_d;
      for (int i = 0; i < int'(NKEYS); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign DIN = din_q;
  assign IRQ = irq_q;

endmodule

// File: tb/tb_key_port.sv
// Self-checking bench for key_port with a short debounce window; expected
// read data and interrupt values are queued at stimulus time and popped on output.
module tb_key_port;

  logic        Clock;
  logic        Reset;
  logic [2:0]  KEY_n;
  logic        cs;
  logic [1:0]  ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] DIN;
  logic        IRQ;

  int checks;
  int errors;
  logic [15:0] din_exp_q [$];
  logic        irq_exp_q [$];
  logic [15:0] din_exp;
  logic        irq_exp;

  key_port #(.DEBOUNCE_CYCLES(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .KEY_n (KEY_n),
    .cs    (cs),
    .ADDR  (ADDR),
    .DOUT  (DOUT),
    .W     (W),
    .DIN   (DIN),
    .IRQ   (IRQ)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    cs = 1'b1; W = 1'b1; ADDR = a; DOUT = d;
    tick();
    cs = 1'b0; W = 1'b0; DOUT = 16'h0000;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1; KEY_n = 3'b111;
    tick(); tick();
    Reset = 1'b0;
    checks++;
    if (DIN !== 16'h0000 || IRQ !== 1'b0) begin
      errors++; $display("FAIL reset_out DIN=%h IRQ=%b exp DIN=0000 IRQ=0", DIN, IRQ);
    end
    for (int a = 0; a < 4; a++) begin
      ADDR = 2'(a);
      din_exp_q.push_back(16'h0000);
      tick();
      din_exp = din_exp_q.pop_front();
      checks++;
      if (DIN !== din_exp) begin
        errors++; $display("FAIL reset_rd%0d DIN=%h exp=%h", a, DIN, din_exp);
      end
    end
    ADDR = 2'd1;
    for (int i = 0; i < 20; i++) begin
      din_exp_q.push_back(16'h0000);
      irq_exp_q.push_back(1'b0);
      tick();
      din_exp = din_exp_q.pop_front();
      irq_exp = irq_exp_q.pop_front();
      checks++;
      if (DIN !== din_exp || IRQ !== irq_exp) begin
        errors++; $display("FAIL reset_quiet cyc%0d DIN=%h IRQ=%b exp=%h/%b", i, DIN, IRQ, din_exp, irq_exp);
      end
    end
  endtask

  task automatic test_press_release();
    ADDR = 2'd0;
    KEY_n = 3'b101;
    for (int n = 1; n <= 7; n++) begin
      din_exp_q.push_back((n == 7) ? 16'h0002 : 16'h0000);
      tick();
      din_exp = din_exp_q.pop_front();
      checks++;
      if (DIN !== din_exp) begin
        errors++; $display("FAIL press_lvl t%0d DIN=%h exp=%h", n, DIN, din_exp);
      end
    end
    ADDR = 2'd1;
    din_exp_q.push_back(16'h0002);
    tick();
    din_exp = din_exp_q.pop_front();
    checks++;
    if (DIN !== din_exp) begin
      errors++; $display("FAIL press_edge DIN=%h exp=%h", DIN, din_exp);
    end
    ADDR = 2'd0;
    KEY_n = 3'b111;
    for (int n = 1; n <= 7; n++) begin
      din_exp_q.push_back((n == 7) ? 16'h0000 : 16'h0002);
      tick();
      din_exp = din_exp_q.pop_front();
      checks++;
      if (DIN !== din_exp) begin
        errors++; $display("FAIL release_lvl t%0d DIN=%h exp=%h", n, DIN, din_exp);
      end
    end
    ADDR = 2'd1;
    din_exp_q.push_back(16'h0002);
    tick();
    din_exp = din_exp_q.pop_front();
    checks++;
    if (DIN !== din_exp) begin
      errors++; $display("FAIL release_edge DIN=%h exp=%h", DIN, din_exp);
    end
  endtask

  task automatic test_glitch();
    ADDR = 2'd0;
    KEY_n = 3'b110;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) KEY_n = 3'b111;
      din_exp_q.push_back(16'h0000);
      tick();
      din_exp = din_exp_q.pop_front();
      checks++;
      if (DIN !== din_exp) begin
        errors++; $display("FAIL glitch_lvl cyc%0d DIN=%h exp=%h", i, DIN, din_exp);
      end
    end
    ADDR = 2'd1;
    din_exp_q.push_back(16'h0002);
    tick();
    din_exp = din_exp_q.pop_front();
    checks++;
    if (DIN !== din_exp) begin
      errors++; $display("FAIL glitch_edge DIN=%h exp=%h", DIN, din_exp);
    end
  endtask

  task automatic test_w1c();
    bus_write(2'd1, 16'h0002);
    ADDR = 2'd1;
    din_exp_q.push_back(16'h0000);
    tick();
    din_exp = din_exp_q.pop_front();
    checks++;
    if (DIN !== din_exp) begin
      errors++; $display("FAIL w1c_clear DIN=%h exp=%h", DIN, din_exp);
    end
    // Key 2 press lands on edge 6, the same edge as the clearing write
    KEY_n = 3'b011;
    idle(5);
    bus_write(2'd1, 16'h0004);
    ADDR = 2'd1;
    din_exp_q.push_back(16'h0004);
    tick();
    din_exp = din_exp_q.pop_front();
    checks++;
    if (DIN !== din_exp) begin
      errors++; $display("FAIL w1c_set_wins DIN=%h exp=%h", DIN, din_exp);
    end
    bus_write(2'd0, 16'hFFFF);
    bus_write(2'd3, 16'hFFFF);
    for (int a = 0; a < 4; a += 3) begin
      ADDR = 2'(a);
      din_exp_q.push_back((a == 0) ? 16'h0004 : 16'h0000);
      tick();
      din_exp = din_exp_q.pop_front();
      checks++;
      if (DIN !== din_exp) begin
        errors++; $display("FAIL ro_write_rd%0d DIN=%h exp=%h", a, DIN, din_exp);
      end
    end
    KEY_n = 3'b111;
    idle(8);
    bus_write(2'd1, 16'hFFFF);
  endtask

  task automatic test_irq();
    bus_write(2'd2, 16'hFFFC);
    ADDR = 2'd2;
    din_exp_q.push_back(16'h0004);
    tick();
    din_exp = din_exp_q.pop_front();
    checks++;
    if (DIN !== din_exp) begin
      errors++; $display("FAIL mask_rd DIN=%h exp=%h", DIN, din_exp);
    end
    KEY_n = 3'b011;
    for (int n = 1; n <= 7; n++) begin
      irq_exp_q.push_back(n == 7);
      tick();
      irq_exp = irq_exp_q.pop_front();
      checks++;
      if (IRQ !== irq_exp) begin
        errors++; $display("FAIL irq_rise t%0d IRQ=%b exp=%b", n, IRQ, irq_exp);
      end
    end
    irq_exp_q.push_back(1'b1);
    irq_exp_q.push_back(1'b0);
    bus_write(2'd1, 16'h0004);
    irq_exp = irq_exp_q.pop_front();
    checks++;
    if (IRQ !== irq_exp) begin
      errors++; $display("FAIL irq_clr_same IRQ=%b exp=%b", IRQ, irq_exp);
    end
    tick();
    irq_exp = irq_exp_q.pop_front();
    checks++;
    if (IRQ !== irq_exp) begin
      errors++; $display("FAIL irq_clr_next IRQ=%b exp=%b", IRQ, irq_exp);
    end
    KEY_n = 3'b111;
    idle(8);
    KEY_n = 3'b110;
    for (int i = 0; i < 10; i++) begin
      irq_exp_q.push_back(1'b0);
      tick();
      irq_exp = irq_exp_q.pop_front();
      checks++;
      if (IRQ !== irq_exp) begin
        errors++; $display("FAIL irq_masked cyc%0d IRQ=%b exp=%b", i, IRQ, irq_exp);
      end
    end
    ADDR = 2'd1;
    din_exp_q.push_back(16'h0001);
    tick();
    din_exp = din_exp_q.pop_front();
    checks++;
    if (DIN !== din_exp) begin
      errors++; $display("FAIL masked_edge DIN=%h exp=%h", DIN, din_exp);
    end
    KEY_n = 3'b111;
    idle(8);
    bus_write(2'd1, 16'h0007);
  endtask

  task automatic test_simultaneous();
    ADDR = 2'd1;
    KEY_n = 3'b000;
    for (int n = 1; n <= 7; n++) begin
      din_exp_q.push_back((n == 7) ? 16'h0007 : 16'h0000);
      tick();
      din_exp = din_exp_q.pop_front();
      checks++;
      if (DIN !== din_exp) begin
        errors++; $display("FAIL simul_edge t%0d DIN=%h exp=%h", n, DIN, din_exp);
      end
    end
    KEY_n = 3'b111;
    idle(8);
    bus_write(2'd1, 16'h0007);
  endtask

  task automatic test_reset_mid();
    ADDR = 2'd0;
    KEY_n = 3'b011;
    idle(3);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (DIN !== 16'h0000 || IRQ !== 1'b0) begin
      errors++; $display("FAIL midrst_out DIN=%h IRQ=%b exp DIN=0000 IRQ=0", DIN, IRQ);
    end
    for (int k = 1; k <= 7; k++) begin
      din_exp_q.push_back((k == 7) ? 16'h0004 : 16'h0000);
      tick();
      din_exp = din_exp_q.pop_front();
      checks++;
      if (DIN !== din_exp) begin
        errors++; $display("FAIL midrst_lvl t%0d DIN=%h exp=%h", k, DIN, din_exp);
      end
    end
    ADDR = 2'd2;
    din_exp_q.push_back(16'h0000);
    tick();
    din_exp = din_exp_q.pop_front();
    checks++;
    if (DIN !== din_exp) begin
      errors++; $display("FAIL midrst_mask DIN=%h exp=%h", DIN, din_exp);
    end
    KEY_n = 3'b111;
    idle(8);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    KEY_n  = 3'b111;
    cs     = 1'b0;
    W      = 1'b0;
    ADDR   = 2'd0;
    DOUT   = 16'h0000;
    test_reset();
    test_press_release();
    test_glitch();
    test_w1c();
    test_irq();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
